// File: rtl/basic_block.sv
// Single-instruction regex engine block: fetches one instruction at a PC,
// evaluates it against the current character and emits follow-on PCs.
module basic_block #(
    parameter int PC_WIDTH          = 8,
    parameter int CHARACTER_WIDTH   = 8,
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHARACTER_WIDTH-1:0]   current_character,
    input  logic                         input_pc_valid,
    input  logic [PC_WIDTH-1:0]          input_pc,
    output logic                         input_pc_ready,
    output logic                         memory_valid,
    output logic [MEMORY_ADDR_WIDTH-1:0] memory_addr,
    input  logic                         memory_ready,
    input  logic [MEMORY_WIDTH-1:0]      memory_data,
    output logic                         output_pc_valid,
    output logic [PC_WIDTH-1:0]          output_pc,
    output logic                         output_pc_is_directed_to_current,
    input  logic                         output_pc_ready,
    output logic                         accepts
);

    localparam int INSTRUCTION_DATA_WIDTH = 13;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_DATA,
        EXEC,
        OUT1,
        OUT2
    } state_t;

    typedef enum logic [2:0] {
        OP_ACCEPT                = 3'b000,
        OP_SPLIT                 = 3'b001,
        OP_MATCH                 = 3'b010,
        OP_JMP                   = 3'b011,
        OP_END_WITHOUT_ACCEPTING = 3'b100,
        OP_MATCH_ANY             = 3'b101,
        OP_ACCEPT_PARTIAL        = 3'b110,
        OP_NOT_MATCH             = 3'b111
    } opcode_t;

    state_t                     state_q;
    state_t                     state_d;
    logic [PC_WIDTH-1:0]        pc_reg;
    logic [MEMORY_WIDTH-1:0]    instr_q;
    logic [PC_WIDTH-1:0]        out_pc_q;
    logic                       out_dir_q;
    logic                       split_q;
    logic [PC_WIDTH-1:0]        split_pc_q;
    logic                       accepts_q;

    opcode_t                    opcode;
    logic [CHARACTER_WIDTH-1:0] instr_char;
    logic [PC_WIDTH-1:0]        instr_target;
    logic [PC_WIDTH-1:0]        pc_inc;
    logic                       char_eq;

    logic                       exec_emit;
    logic [PC_WIDTH-1:0]        exec_pc;
    logic                       exec_dir;
    logic                       exec_split;
    logic                       exec_accept;

    logic                       out_xfer;
    logic                       unused_instr_bits;

    assign opcode       = opcode_t'(instr_q[INSTRUCTION_DATA_WIDTH +: 3]);
    assign instr_char   = instr_q[CHARACTER_WIDTH-1:0];
    assign instr_target = instr_q[PC_WIDTH-1:0];
    assign pc_inc       = pc_reg + 1'b1;
    assign char_eq      = (current_character == instr_char);

    // Payload bits above the char/target fields carry no meaning here.
    assign unused_instr_bits = ^instr_q;

    always_comb begin
        exec_emit   = 1'b0;
        exec_pc     = pc_inc;
        exec_dir    = 1'b0;
        exec_split  = 1'b0;
        exec_accept = 1'b0;
        unique case (opcode)
            OP_MATCH: begin
                exec_emit = char_eq;
            end
            OP_NOT_MATCH: begin
                exec_emit = !char_eq;
            end
            OP_MATCH_ANY: begin
                exec_emit = 1'b1;
            end
            OP_JMP: begin
                exec_emit = 1'b1;
                exec_pc   = instr_target;
                exec_dir  = 1'b1;
            end
            OP_SPLIT: begin
                exec_emit  = 1'b1;
                exec_dir   = 1'b1;
                exec_split = 1'b1;
            end
            OP_ACCEPT: begin
                exec_accept = (current_character == '0);
            end
            OP_ACCEPT_PARTIAL: begin
                exec_accept = 1'b1;
            end
            OP_END_WITHOUT_ACCEPTING: begin
                exec_accept = 1'b0;
            end
            default: begin
                exec_emit = 1'b0;
            end
        endcase
    end

    assign out_xfer = output_pc_ready && ((state_q == OUT1) || (state_q == OUT2));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (input_pc_valid) state_d = FETCH;
            end
            FETCH: begin
                if (memory_ready) state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                state_d = EXEC;
            end
            EXEC: begin
                state_d = exec_emit ? OUT1 : IDLE;
            end
            OUT1: begin
                if (output_pc_ready) state_d = split_q ? OUT2 : IDLE;
            end
            OUT2: begin
                if (output_pc_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_reg     <= '0;
            instr_q    <= '0;
            out_pc_q   <= '0;
            out_dir_q  <= 1'b0;
            split_q    <= 1'b0;
            split_pc_q <= '0;
            accepts_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            accepts_q <= (state_q == EXEC) && exec_accept;
            if ((state_q == IDLE) && input_pc_valid) begin
                pc_reg <= input_pc;
            end
            if (state_q == WAIT_DATA) begin
                instr_q <= memory_data;
            end
            if ((state_q == EXEC) && exec_emit) begin
                out_pc_q   <= exec_pc;
                out_dir_q  <= exec_dir;
                split_q    <= exec_split;
                split_pc_q <= instr_target;
            end
            // Second half of a SPLIT: swap in the branch target once OUT1 drains.
            if ((state_q == OUT1) && out_xfer && split_q) begin
                out_pc_q  <= split_pc_q;
                out_dir_q <= 1'b1;
                split_q   <= 1'b0;
            end
        end
    end

    assign input_pc_ready  = (state_q == IDLE);
    assign memory_valid    = (state_q == FETCH);
    assign memory_addr     = MEMORY_ADDR_WIDTH'(pc_reg);
    assign output_pc_valid = (state_q == OUT1) || (state_q == OUT2);
    assign output_pc       = out_pc_q;
    assign output_pc_is_directed_to_current = out_dir_q;
    assign accepts         = accepts_q;

endmodule

// File: tb/tb_basic_block.sv
// Directed self-checking bench for basic_block: instruction table,
// END_WITHOUT_ACCEPTING sweep and reset-abort sequences.
module tb_basic_block;

    logic        clk;
    logic        reset;
    logic [7:0]  current_character;
    logic        input_pc_valid;
    logic [7:0]  input_pc;
    logic        input_pc_ready;
    logic        memory_valid;
    logic [10:0] memory_addr;
    logic        memory_ready;
    logic [15:0] memory_data;
    logic        output_pc_valid;
    logic [7:0]  output_pc;
    logic        output_pc_is_directed_to_current;
    logic        output_pc_ready;
    logic        accepts;

    int checks;
    int failures;

    basic_block dut (
        .clk                              (clk),
        .reset                            (reset),
        .current_character                (current_character),
        .input_pc_valid                   (input_pc_valid),
        .input_pc                         (input_pc),
        .input_pc_ready                   (input_pc_ready),
        .memory_valid                     (memory_valid),
        .memory_addr                      (memory_addr),
        .memory_ready                     (memory_ready),
        .memory_data                      (memory_data),
        .output_pc_valid                  (output_pc_valid),
        .output_pc                        (output_pc),
        .output_pc_is_directed_to_current (output_pc_is_directed_to_current),
        .output_pc_ready                  (output_pc_ready),
        .accepts                          (accepts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] ACC  = 3'b000;
    localparam logic [2:0] SPL  = 3'b001;
    localparam logic [2:0] MAT  = 3'b010;
    localparam logic [2:0] JMP  = 3'b011;
    localparam logic [2:0] ENDW = 3'b100;
    localparam logic [2:0] ANY  = 3'b101;
    localparam logic [2:0] ACCP = 3'b110;
    localparam logic [2:0] NMAT = 3'b111;

    typedef struct {
        string      name;
        logic [7:0] pc;
        logic [2:0] op;
        logic [12:0] pay;
        logic [7:0] ch;
        int         mdly;
        int         odly;
        int         n;
        logic [7:0] p0;
        logic       d0;
        logic [7:0] p1;
        int         acc;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one PC, serve memory, drain outputs; records what came out.
    task automatic run(input logic [7:0] pc, input logic [15:0] word,
                       input logic [7:0] ch, input int mdly, input int odly,
                       output int n_out, output logic [7:0] p0,
                       output logic d0, output logic [7:0] p1,
                       output logic d1, output int n_acc,
                       output int fetch_cnt, output int bad);
        int hold;
        logic [7:0] cur_p;
        logic cur_d;
        n_out = 0; n_acc = 0; fetch_cnt = 0; bad = 0; hold = 0;
        p0 = '0; p1 = '0; d0 = 1'b0; d1 = 1'b0;
        cur_p = '0; cur_d = 1'b0;
        @(negedge clk);
        current_character = ch;
        memory_data = word;
        memory_ready = 1'b0;
        output_pc_ready = 1'b0;
        input_pc = pc;
        input_pc_valid = 1'b1;
        if (!input_pc_ready) bad++;
        @(negedge clk);
        input_pc_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            if (accepts) n_acc++;
            if (memory_valid) begin
                fetch_cnt++;
                if (memory_addr !== {3'b000, pc}) bad++;
                memory_ready = (fetch_cnt > mdly);
            end else begin
                memory_ready = 1'b0;
            end
            if (output_pc_valid) begin
                if (hold == 0) begin
                    cur_p = output_pc;
                    cur_d = output_pc_is_directed_to_current;
                end else if (output_pc !== cur_p ||
                             output_pc_is_directed_to_current !== cur_d) begin
                    bad++;
                end
                if (hold >= odly) begin
                    output_pc_ready = 1'b1;
                    if (n_out == 0) begin p0 = cur_p; d0 = cur_d; end
                    if (n_out == 1) begin p1 = cur_p; d1 = cur_d; end
                    n_out++;
                    hold = 0;
                end else begin
                    output_pc_ready = 1'b0;
                    hold++;
                end
            end else begin
                output_pc_ready = 1'b0;
                hold = 0;
            end
        end
        output_pc_ready = 1'b0;
        memory_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_valid"}, 32'(memory_valid), 32'd0);
        chk({tag, "_mem_addr"}, 32'(memory_addr), 32'd0);
        chk({tag, "_out_valid"}, 32'(output_pc_valid), 32'd0);
        chk({tag, "_out_pc"}, 32'(output_pc), 32'd0);
        chk({tag, "_out_dir"}, 32'(output_pc_is_directed_to_current), 32'd0);
        chk({tag, "_accepts"}, 32'(accepts), 32'd0);
        chk({tag, "_in_ready"}, 32'(input_pc_ready), 32'd1);
    endtask

    initial begin
        int n_out, n_acc, fcnt, bad, quiet;
        logic [7:0] p0, p1;
        logic d0, d1;
        checks = 0;
        failures = 0;

        vecs[0]  = '{"match_hit",   8'd5,   MAT,  13'h0061, 8'h61, 0, 0, 1, 8'd6,   1'b0, 8'd0,  0};
        vecs[1]  = '{"match_miss",  8'd5,   MAT,  13'h0061, 8'h62, 0, 0, 0, 8'd0,   1'b0, 8'd0,  0};
        vecs[2]  = '{"nmatch_hit",  8'd7,   NMAT, 13'h0061, 8'h62, 0, 0, 1, 8'd8,   1'b0, 8'd0,  0};
        vecs[3]  = '{"nmatch_miss", 8'd7,   NMAT, 13'h0061, 8'h61, 0, 0, 0, 8'd0,   1'b0, 8'd0,  0};
        vecs[4]  = '{"any_wrap",    8'd255, ANY,  13'h0000, 8'h33, 0, 1, 1, 8'd0,   1'b0, 8'd0,  0};
        vecs[5]  = '{"jmp",         8'd3,   JMP,  13'h0040, 8'h10, 0, 0, 1, 8'h40,  1'b1, 8'd0,  0};
        vecs[6]  = '{"split",       8'd10,  SPL,  13'd20,   8'h10, 0, 2, 2, 8'd11,  1'b1, 8'd20, 0};
        vecs[7]  = '{"acc_zero",    8'd1,   ACC,  13'h0055, 8'h00, 0, 0, 0, 8'd0,   1'b0, 8'd0,  1};
        vecs[8]  = '{"acc_nz",      8'd1,   ACC,  13'h0055, 8'h41, 0, 0, 0, 8'd0,   1'b0, 8'd0,  0};
        vecs[9]  = '{"accp",        8'd2,   ACCP, 13'h0000, 8'h41, 0, 0, 0, 8'd0,   1'b0, 8'd0,  1};
        vecs[10] = '{"end",         8'd9,   ENDW, 13'h0123, 8'h00, 0, 0, 0, 8'd0,   1'b0, 8'd0,  0};
        vecs[11] = '{"match_hibits",8'd0,   MAT,  13'h1F61, 8'h61, 0, 0, 1, 8'd1,   1'b0, 8'd0,  0};
        vecs[12] = '{"jmp_hibits",  8'd77,  JMP,  13'h1FAB, 8'h00, 0, 3, 1, 8'hAB,  1'b1, 8'd0,  0};
        vecs[13] = '{"match_mwait", 8'd40,  MAT,  13'h007A, 8'h7A, 3, 0, 1, 8'd41,  1'b0, 8'd0,  0};

        reset = 1'b0;
        current_character = '0;
        input_pc_valid = 1'b0;
        input_pc = '0;
        memory_ready = 1'b0;
        memory_data = '0;
        output_pc_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[k]) begin
            run(vecs[k].pc, {vecs[k].op, vecs[k].pay}, vecs[k].ch,
                vecs[k].mdly, vecs[k].odly,
                n_out, p0, d0, p1, d1, n_acc, fcnt, bad);
            chk({vecs[k].name, "_n_out"}, 32'(n_out), 32'(vecs[k].n));
            if (vecs[k].n >= 1) begin
                chk({vecs[k].name, "_pc0"}, 32'(p0), 32'(vecs[k].p0));
                chk({vecs[k].name, "_dir0"}, 32'(d0), 32'(vecs[k].d0));
            end
            if (vecs[k].n >= 2) begin
                chk({vecs[k].name, "_pc1"}, 32'(p1), 32'(vecs[k].p1));
                chk({vecs[k].name, "_dir1"}, 32'(d1), 32'd1);
            end
            chk({vecs[k].name, "_accepts"}, 32'(n_acc), 32'(vecs[k].acc));
            chk({vecs[k].name, "_fetch"}, 32'(fcnt), 32'(vecs[k].mdly + 1));
            chk({vecs[k].name, "_proto"}, 32'(bad), 32'd0);
            chk({vecs[k].name, "_idle"}, 32'(input_pc_ready), 32'd1);
        end

        for (int p = 0; p < 128; p += 11) begin
            run(8'(p), {ENDW, 13'(p * 37 + 5)}, 8'(p % 64), 0, 0,
                n_out, p0, d0, p1, d1, n_acc, fcnt, bad);
            quiet = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (!input_pc_ready || output_pc_valid || memory_valid) quiet++;
            end
            chk($sformatf("endw_pc%0d", p),
                32'(n_out + n_acc + bad + quiet + (fcnt == 1 ? 0 : 100)), 32'd0);
        end

        @(negedge clk);
        memory_data = {JMP, 13'h0040};
        memory_ready = 1'b1;
        input_pc = 8'd3;
        input_pc_valid = 1'b1;
        @(negedge clk);
        input_pc_valid = 1'b0;
        chk("rst_wd_fetching", 32'(memory_valid), 32'd1);
        @(negedge clk);
        memory_ready = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_wd");
        @(negedge clk);
        reset = 1'b1;
        quiet = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (output_pc_valid || accepts || !input_pc_ready) quiet++;
        end
        chk("rst_wd_quiet", 32'(quiet), 32'd0);

        @(negedge clk);
        memory_data = {SPL, 13'd20};
        memory_ready = 1'b1;
        input_pc = 8'd10;
        input_pc_valid = 1'b1;
        @(negedge clk);
        input_pc_valid = 1'b0;
        repeat (3) @(negedge clk);
        memory_ready = 1'b0;
        chk("rst_o1_valid_before", 32'(output_pc_valid), 32'd1);
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_o1");
        @(negedge clk);
        reset = 1'b1;
        output_pc_ready = 1'b1;
        quiet = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (output_pc_valid || accepts || !input_pc_ready) quiet++;
        end
        output_pc_ready = 1'b0;
        chk("rst_o1_quiet", 32'(quiet), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
